// File: rtl/ram512_reader.sv
// Sweeps a 512x16 memory reading len words from base, summing and checking against seed+i.
// Latency: one word sampled per cycle after start; done pulses the cycle after the last sample.
// Backpressure: none; start is honoured only in IDLE and ignored otherwise (no queueing).
module ram512_reader (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [8:0]  base,
  input  logic [9:0]  len,
  input  logic [15:0] seed,
  input  logic [15:0] mem_out,
  output logic [8:0]  mem_address,
  output logic        mem_load,
  output logic [15:0] mem_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] checksum,
  output logic [9:0]  mismatches,
  output logic [8:0]  first_bad,
  output logic        first_bad_valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [8:0]  base_q;     // sweep start, restored onto mem_address once the sweep ends
  logic [9:0]  remaining;  // words still to sample in this sweep
  logic [15:0] expected;   // expected value of the word currently addressed
  logic [9:0]  len_clip;

  // Lengths above a full memory collapse to one full pass.
  assign len_clip = (len > 10'd512) ? 10'd512 : len;

  // This block only ever reads the memory.
  assign mem_load = 1'b0;
  assign mem_in   = 16'd0;

  // Sweep FSM with registered status and result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      base_q          <= 9'd0;
      remaining       <= 10'd0;
      expected        <= 16'd0;
      mem_address     <= 9'd0;
      busy            <= 1'b0;
      done            <= 1'b0;
      checksum        <= 16'd0;
      mismatches      <= 10'd0;
      first_bad       <= 9'd0;
      first_bad_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            base_q          <= base;
            mem_address     <= base;
            expected        <= seed;
            remaining       <= len_clip;
            checksum        <= 16'd0;
            mismatches      <= 10'd0;
            first_bad       <= 9'd0;
            first_bad_valid <= 1'b0;
            busy            <= 1'b1;
            if (len_clip == 10'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          checksum <= checksum + mem_out;
          if (mem_out != expected) begin
            mismatches <= mismatches + 10'd1;
            if (!first_bad_valid) begin
              first_bad       <= mem_address;
              first_bad_valid <= 1'b1;
            end
          end
          expected  <= expected + 16'd1;
          remaining <= remaining - 10'd1;
          if (remaining == 10'd1) begin
            state       <= DONE;
            done        <= 1'b1;
            mem_address <= base_q;
          end else begin
            // 9-bit increment wraps 511 -> 0 naturally.
            mem_address <= mem_address + 9'd1;
          end
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram512_reader.sv
// Directed bench for ram512_reader with a sweep-level reference model and per-cycle compare.
// Model advances one sampled word per cycle from the captured start parameters.
// Memory is modelled as an array driven combinationally onto mem_out.
module tb_ram512_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [8:0]  base;
  logic [9:0]  len;
  logic [15:0] seed;
  logic [15:0] mem_out;
  logic [8:0]  mem_address;
  logic        mem_load;
  logic [15:0] mem_in;
  logic        busy;
  logic        done;
  logic [15:0] checksum;
  logic [9:0]  mismatches;
  logic [8:0]  first_bad;
  logic        first_bad_valid;

  logic [15:0] mem [512];

  int total = 0;
  int bad   = 0;

  ram512_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base(base), .len(len), .seed(seed),
    .mem_out(mem_out), .mem_address(mem_address), .mem_load(mem_load), .mem_in(mem_in),
    .busy(busy), .done(done), .checksum(checksum), .mismatches(mismatches),
    .first_bad(first_bad), .first_bad_valid(first_bad_valid)
  );

  always #5 clk = ~clk;

  assign mem_out = mem[mem_address];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 reading, 2 done; m_t = words sampled so far.
  int m_ph = 0, m_t = 0, m_len = 0, m_base = 0, m_seed = 0;
  int m_cs = 0, m_mm = 0, m_fb = 0, m_fbv = 0;

  always @(posedge clk) begin
    int a;
    int w;
    if (!rst_n) begin
      m_ph = 0; m_t = 0; m_len = 0; m_base = 0; m_seed = 0;
      m_cs = 0; m_mm = 0; m_fb = 0; m_fbv = 0;
    end else begin
      case (m_ph)
        0: if (start) begin
          m_base = int'(base);
          m_seed = int'(seed);
          m_len  = (int'(len) > 512) ? 512 : int'(len);
          m_t = 0; m_cs = 0; m_mm = 0; m_fb = 0; m_fbv = 0;
          m_ph = (m_len == 0) ? 2 : 1;
        end
        1: begin
          a = (m_base + m_t) % 512;
          w = int'(mem[a]);
          m_cs = (m_cs + w) % 65536;
          if (w != (m_seed + m_t) % 65536) begin
            m_mm++;
            if (m_fbv == 0) begin
              m_fb  = a;
              m_fbv = 1;
            end
          end
          m_t++;
          if (m_t == m_len) m_ph = 2;
        end
        default: m_ph = 0;
      endcase
    end
  end

  // Per-cycle compare of every output against the model, away from the active edge.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("addr", 32'(mem_address), (m_ph == 1) ? 32'((m_base + m_t) % 512) : 32'(m_base));
      chk("busy", 32'(busy), 32'(m_ph != 0));
      chk("done", 32'(done), 32'(m_ph == 2));
      chk("checksum", 32'(checksum), 32'(m_cs));
      chk("mismatches", 32'(mismatches), 32'(m_mm));
      chk("first_bad", 32'(first_bad), 32'(m_fb));
      chk("first_bad_valid", 32'(first_bad_valid), 32'(m_fbv));
      chk("mem_load", 32'(mem_load), 32'd0);
      chk("mem_in", 32'(mem_in), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Launch a sweep, measure start-to-done cycles, then check hand-computed results.
  task automatic run_sweep(input string nm, input [8:0] b, input [9:0] l, input [15:0] s,
                           input int ecyc, input [15:0] ecs, input [9:0] emm,
                           input logic efbv, input [8:0] efb);
    int n;
    base = b; len = l; seed = s; start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    n = 1;
    @(negedge clk);
    while (done !== 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_cycles"}, 32'(n), 32'(ecyc));
    chk({nm, "_checksum"}, 32'(checksum), 32'(ecs));
    chk({nm, "_mismatches"}, 32'(mismatches), 32'(emm));
    chk({nm, "_fbv"}, 32'(first_bad_valid), 32'(efbv));
    if (efbv) chk({nm, "_first_bad"}, 32'(first_bad), 32'(efb));
    tick();
    chk({nm, "_idle_busy"}, 32'(busy), 32'd0);
    chk({nm, "_hold_checksum"}, 32'(checksum), 32'(ecs));
  endtask

  initial begin
    int seen_done;
    for (int k = 0; k < 512; k++) mem[k] = 16'(k);
    rst_n = 1'b0; start = 1'b1; base = 9'd100; len = 10'd4; seed = 16'd0;
    repeat (2) tick();
    chk("rst_addr", 32'(mem_address), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("idle_after_rst_busy", 32'(busy), 32'd0);

    run_sweep("basic",  9'd0,   10'd4,   16'd0,   5,   16'd6,      10'd0, 1'b0, 9'd0);
    mem[2] = 16'hFFFF;
    run_sweep("onebad", 9'd0,   10'd4,   16'd0,   5,   16'h0003,   10'd1, 1'b1, 9'd2);
    mem[2] = 16'd2;
    run_sweep("wrap",   9'd510, 10'd4,   16'd510, 5,   16'd1022,   10'd2, 1'b1, 9'd0);
    run_sweep("len0",   9'd7,   10'd0,   16'd0,   1,   16'd0,      10'd0, 1'b0, 9'd0);
    chk("len0_addr_holds_base", 32'(mem_address), 32'd7);
    run_sweep("full",   9'd0,   10'd512, 16'd0,   513, 16'hFF00,   10'd0, 1'b0, 9'd0);
    run_sweep("len600", 9'd0,   10'd600, 16'd0,   513, 16'hFF00,   10'd0, 1'b0, 9'd0);

    // Reset two cycles into a len=8 sweep: aborts with all outputs cleared, no done.
    base = 9'd3; len = 10'd8; seed = 16'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_addr", 32'(mem_address), 32'd0);
    chk("abort_checksum", 32'(checksum), 32'd0);
    seen_done = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done === 1'b1) seen_done = 1;
    end
    chk("abort_no_done", 32'(seen_done), 32'd0);

    // Start during READ with different parameters must not disturb the sweep.
    base = 9'd0; len = 10'd8; seed = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    base = 9'd200; len = 10'd2; seed = 16'd99; start = 1'b1;
    tick();
    start = 1'b0;
    base = 9'd0; len = 10'd8; seed = 16'd0;
    for (int c = 0; c < 20 && done !== 1'b1; c++) tick();
    chk("midstart_done", 32'(done), 32'd1);
    chk("midstart_checksum", 32'(checksum), 32'd28);
    chk("midstart_mismatches", 32'(mismatches), 32'd0);
    tick();
    tick();
    chk("midstart_no_restart", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram512_reader.md
RAM512_READER -- requirements
Module: ram512_reader

Interface
REQ-001 The block SHALL have no parameters; widths are fixed for a 512 x 16 memory.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  sweep request; sampled only in IDLE.
REQ-005 base  input  9  first address of the sweep; captured on accepted start.
REQ-006 len  input  10  number of words to read, 0..512; values above 512 are treated as 512; captured on accepted start.
REQ-007 seed  input  16  expected value of word 0; captured on accepted start.
REQ-008 mem_out  input  16  read data from a ram512-compatible memory, combinational on mem_address.
REQ-009 mem_address  output  9  address driven to the memory.
REQ-010 mem_load  output  1  memory write enable; constant 0.
REQ-011 mem_in  output  16  memory write data; constant 0.
REQ-012 busy  output  1  high in READ and DONE.
REQ-013 done  output  1  one-cycle pulse when the sweep completes.
REQ-014 checksum  output  16  modulo-2^16 sum of all words read.
REQ-015 mismatches  output  10  count of words whose value differs from the expected value.
REQ-016 first_bad  output  9  address of the first mismatching word.
REQ-017 first_bad_valid  output  1  high once any mismatch is recorded.

Function
REQ-018 The FSM SHALL have the states IDLE, READ and DONE.
REQ-019 IDLE -> READ on a clock edge with start=1 and len!=0.
REQ-020 IDLE -> DONE on a clock edge with start=1 and len=0.
REQ-021 READ -> DONE on the edge that samples the last word.
REQ-022 DONE -> IDLE unconditionally after one cycle.
REQ-023 An accepted start SHALL clear checksum, mismatches, first_bad and first_bad_valid on the same edge.
REQ-024 In READ, word index i (0..len-1) SHALL be presented as mem_address = (base + i) mod 512, so a sweep wraps from 511 to 0.
REQ-025 mem_out SHALL be sampled at the edge ending the cycle in which its address is driven: exactly one word per cycle, with no wait states.
REQ-026 Expected value of word i SHALL be (seed + i) mod 2^16.
REQ-027 On each sample, checksum SHALL become (checksum + mem_out) mod 2^16.
REQ-028 On each sample with mem_out != expected, mismatches SHALL increment.
REQ-029 first_bad and first_bad_valid SHALL update only on the first mismatch of a sweep.
REQ-030 Latency SHALL be: start accepted at edge E0; samples taken at edges E1..E_len; done high in the cycle after E_len; state back in IDLE one cycle later.
REQ-031 For len=0, done SHALL pulse in the cycle after E0 and all results SHALL be 0.
REQ-032 start in READ or DONE SHALL be ignored; no queueing.
REQ-033 Results SHALL hold their values from DONE until the next accepted start.
REQ-034 In IDLE and DONE, mem_address SHALL hold base as last captured (0 after reset).
REQ-035 base, len and seed SHALL be ignored in READ; changing them mid-sweep has no effect.

Reset
REQ-036 rst_n=0 at a clock edge SHALL force IDLE and set every output to 0 (mem_address=0, busy=0, done=0, checksum=0, mismatches=0, first_bad=0, first_bad_valid=0).
REQ-037 A reset during READ or DONE SHALL abort the sweep with no done pulse.
REQ-038 start asserted in the same cycle as rst_n=0 SHALL be ignored.

Verification
REQ-039 Memory preloaded with mem[k]=k for k=0..511; base=0, len=4, seed=0 -> addresses 0,1,2,3 on consecutive cycles; done 5 cycles after start; checksum=6, mismatches=0, first_bad_valid=0.
REQ-040 Same memory with mem[2]=0xFFFF; base=0, len=4, seed=0 -> checksum=0x0003, mismatches=1, first_bad=2, first_bad_valid=1.
REQ-041 Wrap case: base=510, len=4, seed=510 -> addresses 510,511,0,1; mismatches=2, first_bad=0; checksum=(510+511+0+1) mod 65536=1022.
REQ-042 len=0 -> done in the cycle after start, all results 0, mem_load remains 0 throughout; len=600 -> sweep is 512 words long.
REQ-043 Full sweep base=0, len=512, seed=0 over the preloaded memory -> done 513 cycles after start, checksum=0xFF00 (130816 mod 65536), mismatches=0.
REQ-044 Assert rst_n=0 two cycles into a len=8 sweep -> next cycle is IDLE, all outputs 0, no done pulse; also assert start during READ -> no restart and results unaffected.
